// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : CPU-side fetch and data-request signals between the pipelined
//                CPU and mem_responder. The bidirectional data bus is a plain
//                inout port on the responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_responder_if;
    logic [31:0] iaddrbus;
    logic [31:0] ibus;
    logic [31:0] daddrbus;
    logic        memrd;
    logic        memwr;

    modport master (
        output iaddrbus,
        input  ibus,
        output daddrbus,
        output memrd,
        output memwr
    );

    modport slave (
        input  iaddrbus,
        output ibus,
        input  daddrbus,
        input  memrd,
        input  memwr
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Instruction/data memory responder. Clears both word arrays
//                after reset, then serves combinational fetches and loads,
//                edge-triggered stores and host loader writes, and keeps a
//                sticky error flag plus a saturating error count.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int AW = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_responder_if.slave     bus,
    inout  wire       [31:0]   databus,
    input  wire logic          ld_en,
    input  wire logic [AW-1:0] ld_addr,
    input  wire logic [31:0]   ld_data,
    output logic               ready,
    output logic               err,
    output logic [7:0]         err_cnt
);

    localparam int c_DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic            r_ready;
    logic            r_err;
    logic [7:0]      r_err_cnt;
    logic [31:0]     r_imem [c_DEPTH];
    logic [31:0]     r_dmem [c_DEPTH];

    logic            w_run;
    logic [AW-1:0]   w_iidx;
    logic            w_i_oor;
    logic            w_i_mis;
    logic [AW-1:0]   w_didx;
    logic            w_d_oor;
    logic            w_d_mis;
    logic            w_load;
    logic            w_store;
    logic            w_store_ok;
    logic [31:0]     w_rdata;
    logic            w_i_fault;
    logic            w_d_fault;
    logic            w_err_evt;

    assign w_run   = (r_state == ST_RUN);

    // Address decode: word index, out-of-range upper bits, misaligned low bits.
    assign w_iidx  = bus.iaddrbus[AW+1:2];
    assign w_i_oor = |bus.iaddrbus[31:AW+2];
    assign w_i_mis = |bus.iaddrbus[1:0];
    assign w_didx  = bus.daddrbus[AW+1:2];
    assign w_d_oor = |bus.daddrbus[31:AW+2];
    assign w_d_mis = |bus.daddrbus[1:0];

    // A store always wins over a simultaneous load, so the bus is only
    // driven when memwr is low; nothing is served until the clear is done.
    assign w_load     = w_run & bus.memrd & ~bus.memwr;
    assign w_store    = w_run & bus.memwr;
    assign w_store_ok = w_store & ~w_d_oor;

    assign w_rdata = w_d_oor ? 32'h0 : r_dmem[w_didx];
    assign databus = w_load ? w_rdata : 32'bz;

    // Fetch returns NOP while clearing or when the address is off the array.
    assign bus.ibus = (w_run && !w_i_oor) ? r_imem[w_iidx] : 32'h0;

    // Any fault from either port in a cycle collapses to one error event.
    assign w_i_fault = w_run & (w_i_oor | w_i_mis);
    assign w_d_fault = ((w_load | w_store) & (w_d_oor | w_d_mis))
                     | (w_run & bus.memrd & bus.memwr);
    assign w_err_evt = w_i_fault | w_d_fault;

    assign ready   = r_ready;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

    // Clear-sequence FSM: walk every word index once, then serve forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == AW'(c_DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_idx   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag and saturating error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end
        end
    end

    // Array writes: zero fill while clearing, loader and stores once running.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_imem[r_idx] <= 32'h0;
            r_dmem[r_idx] <= 32'h0;
        end else begin
            if (ld_en) begin
                r_imem[ld_addr] <= ld_data;
            end
            if (w_store_ok) begin
                r_dmem[w_didx] <= databus;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int c_AW = 8;

    logic            clk;
    logic            reset;
    logic            ld_en;
    logic [c_AW-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic            ready;
    logic            err;
    logic [7:0]      err_cnt;
    logic            r_drv;
    logic [31:0]     r_drv_data;
    tri1  [31:0]     databus;

    int n_cmp;
    int n_fail;

    mem_responder_if bus ();

    assign databus = r_drv ? r_drv_data : 32'bz;

    mem_responder #(.AW(c_AW)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .databus (databus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ready   (ready),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drop all requests back to an idle, fault-free fetch at 0x10.
    task automatic idle();
        bus.iaddrbus = 32'h10;
        bus.daddrbus = 32'h0;
        bus.memrd    = 1'b0;
        bus.memwr    = 1'b0;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = 32'h0;
        r_drv        = 1'b0;
        r_drv_data   = 32'h0;
    endtask

    // Counts edges from reset release until ready; 0 means it never rose.
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                edges = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        wait_ready(edges);
        n_cmp++;
        if (edges != 256) begin n_fail++; $display("FAIL first_clear_len: got %0d edges, expected 256", edges); end

        // Preload one instruction and one data word.
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 8'd4; ld_data = 32'h2001_0005;
        bus.memwr = 1'b1; bus.daddrbus = 32'h20; r_drv = 1'b1; r_drv_data = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h20;
        #1;
        n_cmp++;
        if (databus !== 32'h5555_AAAA) begin n_fail++; $display("FAIL preload_data: got %h, expected 5555aaaa", databus); end
        n_cmp++;
        if (bus.ibus !== 32'h2001_0005) begin n_fail++; $display("FAIL preload_fetch: got %h, expected 20010005", bus.ibus); end

        // Hold reset for 3 cycles, then measure the clear length.
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || err_cnt !== 8'h00 || bus.ibus !== 32'h0) begin
            n_fail++; $display("FAIL reset_values: got ready=%b err_cnt=%h ibus=%h, expected 0/00/00000000", ready, err_cnt, bus.ibus);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        wait_ready(edges);
        n_cmp++;
        if (edges != 256) begin n_fail++; $display("FAIL clear_len: got %0d edges, expected 256", edges); end

        @(negedge clk);
        bus.memrd = 1'b1; bus.daddrbus = 32'h20;
        #1;
        n_cmp++;
        if (bus.ibus !== 32'h0) begin n_fail++; $display("FAIL cleared_fetch: got %h, expected 00000000", bus.ibus); end
        n_cmp++;
        if (databus !== 32'h0) begin n_fail++; $display("FAIL cleared_load: got %h, expected 00000000", databus); end
        n_cmp++;
        if (err_cnt !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL clear_errs: got err=%b cnt=%h, expected 0/00", err, err_cnt); end
    endtask

    task automatic test_loader_fetch();
        @(negedge clk);
        idle();
        ld_en = 1'b1; ld_addr = 8'd4; ld_data = 32'h2001_0005;
        #1;
        n_cmp++;
        if (bus.ibus !== 32'h0) begin n_fail++; $display("FAIL fetch_before_load: got %h, expected 00000000", bus.ibus); end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ibus !== 32'h2001_0005) begin n_fail++; $display("FAIL fetch_after_load: got %h, expected 20010005", bus.ibus); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_store_load();
        @(negedge clk);
        idle();
        bus.memwr = 1'b1; bus.daddrbus = 32'h40; r_drv = 1'b1; r_drv_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h40;
        #1;
        n_cmp++;
        if (databus !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_then_load: got %h, expected deadbeef", databus); end
        // Store with the CPU not driving: the pull-up must show through.
        @(negedge clk);
        idle();
        bus.memwr = 1'b1; bus.daddrbus = 32'h40;
        #1;
        n_cmp++;
        if (databus !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL store_release: got %h, expected ffffffff (released)", databus); end
        @(negedge clk);
        idle();
        n_cmp++;
        if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL clean_traffic_errs: got %h, expected 00", err_cnt); end
    endtask

    task automatic test_errors();
        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h0000_0400;
        #1;
        n_cmp++;
        if (databus !== 32'h0) begin n_fail++; $display("FAIL oor_load: got %h, expected 00000000", databus); end
        @(posedge clk); #1;
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'h01) begin n_fail++; $display("FAIL err_first: got err=%b cnt=%h, expected 1/01", err, err_cnt); end

        @(negedge clk);
        idle();
        bus.memwr = 1'b1; bus.daddrbus = 32'h42; r_drv = 1'b1; r_drv_data = 32'hCAFE_F00D;
        @(posedge clk);

        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.memwr = 1'b1; bus.daddrbus = 32'h44;
        #1;
        n_cmp++;
        if (databus !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rdwr_no_drive: got %h, expected ffffffff (released)", databus); end
        @(posedge clk); #1;
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'h03) begin n_fail++; $display("FAIL err_three: got err=%b cnt=%h, expected 1/03", err, err_cnt); end

        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h40;
        #1;
        n_cmp++;
        if (databus !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL misaligned_store: got %h, expected cafef00d", databus); end
        @(negedge clk);
        bus.daddrbus = 32'h44;
        #1;
        n_cmp++;
        if (databus !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rdwr_store: got %h, expected ffffffff", databus); end

        // Misaligned fetch and out-of-range load together count once.
        @(negedge clk);
        idle();
        bus.iaddrbus = 32'h11; bus.memrd = 1'b1; bus.daddrbus = 32'h0000_0400;
        @(posedge clk); #1;
        n_cmp++;
        if (err_cnt !== 8'h04) begin n_fail++; $display("FAIL dual_fault_once: got %h, expected 04", err_cnt); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h0000_0400;
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 8'hFF || err !== 1'b1) begin n_fail++; $display("FAIL saturate: got err=%b cnt=%h, expected 1/ff", err, err_cnt); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_midrun();
        int edges;
        @(negedge clk);
        idle();
        bus.memwr = 1'b1; bus.daddrbus = 32'h08; r_drv = 1'b1; r_drv_data = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.memrd = 1'b1; bus.daddrbus = 32'h08;
        #1;
        n_cmp++;
        if (databus !== 32'h0000_1234) begin n_fail++; $display("FAIL midrun_store: got %h, expected 00001234", databus); end

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || err !== 1'b0 || err_cnt !== 8'h00) begin
            n_fail++; $display("FAIL async_reset: got ready=%b err=%b cnt=%h, expected 0/0/00", ready, err, err_cnt);
        end
        n_cmp++;
        if (bus.ibus !== 32'h0 || databus !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL async_reset_bus: got ibus=%h databus=%h, expected 00000000/ffffffff", bus.ibus, databus);
        end
        #7 reset = 1'b1;
        bus.memrd = 1'b0;
        wait_ready(edges);
        n_cmp++;
        if (edges == 0) begin n_fail++; $display("FAIL midrun_ready: got never, expected ready within 400 cycles"); end
        @(negedge clk);
        bus.memrd = 1'b1; bus.daddrbus = 32'h08;
        #1;
        n_cmp++;
        if (databus !== 32'h0) begin n_fail++; $display("FAIL midrun_cleared: got %h, expected 00000000", databus); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        idle();
        test_reset();
        test_loader_fetch();
        test_store_load();
        test_errors();
        test_saturation();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
